// File: rtl/singles_arbiter_pkg.sv
// singles_arbiter_pkg: shared definitions for the singles arbiter.
//   - Output word framing constants (frame marker, single/tag flag values).
//   - Arbiter state encoding.
//   - Time-tag word assembly.
package singles_arbiter_pkg;

    localparam logic [4:0] FRAME_BITS  = 5'b11111;
    localparam logic       SINGLE_FLAG = 1'b1;
    localparam logic       TAG_FLAG    = 1'b0;

    localparam int unsigned TagWordBits    = 128;
    // Everything below the frame marker and the flag bit.
    localparam int unsigned TagPayloadBits = 122;

    typedef enum logic [1:0] {
        StArb   = 2'd0,
        StDrain = 2'd1,
        StTag   = 2'd2
    } arb_state_e;

    // Tag word: frame marker, tag flag, then the zero-extended time-tag value.
    function automatic logic [TagWordBits-1:0] make_tag_word(
        input logic [TagPayloadBits-1:0] payload
    );
        return {FRAME_BITS, TAG_FLAG, payload};
    endfunction

endpackage

// File: rtl/singles_arbiter_rr_pick.sv
// singles_arbiter_rr_pick: round-robin picker.
//   Returns the first set request at or after the pointer, wrapping cyclically.
//   Ports:
//     req_i   - request vector, one bit per requester
//     ptr_i   - index where the search starts
//     valid_o - at least one request is set
//     idx_o   - chosen requester index (0 when valid_o is low)
module singles_arbiter_rr_pick #(
    parameter int unsigned NBLK = 4,
    localparam int unsigned PtrW = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic [NBLK-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic            valid_o,
    output logic [PtrW-1:0] idx_o
);

    always_comb begin
        int unsigned cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NBLK; k++) begin
            cand = (32'(ptr_i) + k) % NBLK;
            if (!valid_o && req_i[cand[PtrW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[PtrW-1:0];
            end
        end
    end

endmodule

// File: rtl/singles_arbiter.sv
// singles_arbiter: merges per-block single-event streams onto one output stream.
//   Blocks are granted round-robin. On period_done the arbiter drains only the
//   blocks flagging a straddling event, then emits one time-tag word and
//   returns to normal arbitration.
//   Ports:
//     clk_i, rst_ni         - clock, asynchronous active-low reset
//     in_valid_i/in_ready_o - per-block handshake (at most one ready bit set)
//     in_data_i             - block i at [i*DATA_BITS +: DATA_BITS]
//     in_stall_i            - block holds an event straddling the period boundary
//     period_done_i         - one-cycle end-of-period pulse
//     tt_value_i            - time-tag value, sampled with period_done_i
//     out_valid_o/out_ready_i, out_data_o, out_is_tag_o - registered output word
//     drain_timeouts_o      - saturating count of tags forced by drain timeout
//     tag_overruns_o        - saturating count of period pulses lost to a pending tag
module singles_arbiter
    import singles_arbiter_pkg::*;
#(
    parameter int unsigned NBLK          = 4,
    parameter int unsigned DATA_BITS     = 128,
    parameter int unsigned TT_BITS       = 48,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NBLK-1:0]           in_valid_i,
    output logic [NBLK-1:0]           in_ready_o,
    input  logic [NBLK*DATA_BITS-1:0] in_data_i,
    input  logic [NBLK-1:0]           in_stall_i,
    input  logic                      period_done_i,
    input  logic [TT_BITS-1:0]        tt_value_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_BITS-1:0]      out_data_o,
    output logic                      out_is_tag_o,
    output logic [15:0]               drain_timeouts_o,
    output logic [15:0]               tag_overruns_o
);

    localparam int unsigned PtrW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int unsigned CntW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_TIMEOUT - 1);

    arb_state_e            state_q;
    logic [PtrW-1:0]       ptr_q;
    logic                  tag_pending_q;
    logic [TT_BITS-1:0]    tt_q;
    logic [CntW-1:0]       to_cnt_q;
    logic                  out_valid_q;
    logic [DATA_BITS-1:0]  out_data_q;
    logic                  out_is_tag_q;
    logic [15:0]           drain_timeouts_q;
    logic [15:0]           tag_overruns_q;

    logic                  free;
    logic [NBLK-1:0]       eligible;
    logic                  pick_valid;
    logic [PtrW-1:0]       pick_idx;
    logic [PtrW-1:0]       next_ptr;
    logic                  to_hit;
    logic                  drain_exit;
    logic                  grant;
    logic [DATA_BITS-1:0]  grant_data;

    singles_arbiter_rr_pick #(
        .NBLK (NBLK)
    ) u_rr_pick (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        free       = !out_valid_q || out_ready_i;
        // While a tag is pending only blocks holding a straddling event may send.
        eligible   = in_valid_i & (tag_pending_q ? in_stall_i : {NBLK{1'b1}});
        to_hit     = (to_cnt_q == CntLast);
        drain_exit = (state_q == StDrain) && free && ((in_stall_i == '0) || to_hit);
        // Reset gates the grant so in_ready drops the moment reset asserts.
        grant      = rst_ni && free && pick_valid &&
                     ((state_q == StArb) || ((state_q == StDrain) && !drain_exit));
        grant_data = in_data_i[32'(pick_idx)*DATA_BITS +: DATA_BITS];
        if (32'(pick_idx) == NBLK - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = pick_idx + PtrW'(1);
        end
        in_ready_o = '0;
        if (grant) begin
            in_ready_o[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StArb;
            ptr_q            <= '0;
            tag_pending_q    <= 1'b0;
            tt_q             <= '0;
            to_cnt_q         <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_is_tag_q     <= 1'b0;
            drain_timeouts_q <= '0;
            tag_overruns_q   <= '0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (grant) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= grant_data;
                out_is_tag_q <= 1'b0;
                ptr_q        <= next_ptr;
            end

            // A second pulse before the tag leaves is lost; the first value is kept.
            if (period_done_i) begin
                if (tag_pending_q) begin
                    if (tag_overruns_q != 16'hFFFF) begin
                        tag_overruns_q <= tag_overruns_q + 16'd1;
                    end
                end else begin
                    tt_q          <= tt_value_i;
                    tag_pending_q <= 1'b1;
                end
            end

            unique case (state_q)
                StArb: begin
                    if (tag_pending_q) begin
                        state_q  <= StDrain;
                        to_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    if (!to_hit) begin
                        to_cnt_q <= to_cnt_q + CntW'(1);
                    end
                    if (drain_exit) begin
                        state_q <= StTag;
                        // Only a forced exit with stalls still outstanding is a timeout.
                        if (to_hit && (in_stall_i != '0) && (drain_timeouts_q != 16'hFFFF)) begin
                            drain_timeouts_q <= drain_timeouts_q + 16'd1;
                        end
                    end
                end
                StTag: begin
                    if (free) begin
                        out_valid_q   <= 1'b1;
                        out_data_q    <= make_tag_word(TagPayloadBits'(tt_q));
                        out_is_tag_q  <= 1'b1;
                        tag_pending_q <= 1'b0;
                        state_q       <= StArb;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;
    assign out_is_tag_o     = out_is_tag_q;
    assign drain_timeouts_o = drain_timeouts_q;
    assign tag_overruns_o   = tag_overruns_q;

endmodule
